sar_ctrl: RTL and testbench

SAR_CTRL -- requirements
Module: sar_ctrl

---
 rtl/sar_pkg.sv | 18 +
 rtl/sar_settle_cnt.sv | 42 ++++
 rtl/sar_ctrl.sv | 124 ++++++++++++
 tb/tb_sar_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and sizing helpers for the SAR conversion controller.
package sar_pkg;

    // Controller phases of one conversion.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        TRIAL  = 2'd2,
        DONE   = 2'd3
    } sar_state_e;

    // Bits needed to hold values 0..max_val; never less than one bit so a
    // zero-valued count still gets a real register.
    function automatic int sar_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sar_settle_cnt.sv
// Per-bit DAC settle timer: reloaded when a new trial bit starts, flags the
// cycle on which the comparator output is trusted.
module sar_settle_cnt
    import sar_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic clock,
    input  logic rst,
    input  logic load_i,
    output logic last_o
);

    localparam int CW = sar_cnt_w(SETTLE);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on bit entry, then count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = SETTLE_C;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With SETTLE=0 the counter stays at zero, so every trial cycle is final.
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample, resolve WIDTH bits MSB
// first against an external comparator, then publish the code with a pulse.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp,
    output logic             sample,
    output logic [WIDTH-1:0] dac,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int BW = sar_cnt_w(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};

    sar_state_e       state_q;
    logic [BW-1:0]    bit_q;
    logic [WIDTH-1:0] dac_q;
    logic [WIDTH-1:0] result_q;
    logic             sample_q;
    logic             busy_q;
    logic             valid_q;

    logic             settle_last;
    logic             settle_load;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] decided;
    logic [WIDTH-1:0] next_trial;

    // The trial code is the decided upper bits plus the bit under test, so the
    // decision only has to keep or drop that one bit; the next trial then adds
    // the bit one position lower.
    always_comb begin
        bit_mask    = LSB_ONLY << bit_q;
        decided     = cmp ? dac_q : (dac_q & ~bit_mask);
        next_trial  = decided | (bit_mask >> 1);
        settle_load = (state_q == SAMPLE) || ((state_q == TRIAL) && settle_last);
    end

    sar_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clock  (clock),
        .rst    (rst),
        .load_i (settle_load),
        .last_o (settle_last)
    );

    // Conversion sequencer; every output is a register updated alongside state.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            dac_q    <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    dac_q <= '0;
                    if (start) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                SAMPLE: begin
                    state_q <= TRIAL;
                    bit_q   <= BW'(WIDTH - 1);
                    dac_q   <= MSB_ONLY;
                end
                TRIAL: begin
                    if (settle_last) begin
                        if (bit_q == '0) begin
                            state_q  <= DONE;
                            result_q <= decided;
                            valid_q  <= 1'b1;
                            dac_q    <= '0;
                        end else begin
                            bit_q <= bit_q - 1'b1;
                            dac_q <= next_trial;
                        end
                    end
                end
                DONE: begin
                    dac_q <= '0;
                    if (start) begin
                        state_q  <= SAMPLE;
                        sample_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dac_q   <= '0;
                end
            endcase
        end
    end

    assign sample = sample_q;
    assign dac    = dac_q;
    assign busy   = busy_q;
    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Bench for sar_ctrl: a directed 4-bit conversion plus a randomized 8-bit run
// with settle cycles, checked against a timeline model of the conversion.
module tb_sar_ctrl;

    localparam int W     = 8;
    localparam int S     = 2;
    localparam int TDONE = 2 + W * (S + 1);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance: WIDTH=8, SETTLE=2
    logic         rst, start, cmp;
    logic         sample, busy, valid;
    logic [W-1:0] dac, result;

    sar_ctrl #(.WIDTH(W), .SETTLE(S)) u_dut (
        .clock  (clock),
        .rst    (rst),
        .start  (start),
        .cmp    (cmp),
        .sample (sample),
        .dac    (dac),
        .busy   (busy),
        .result (result),
        .valid  (valid)
    );

    // Small instance: WIDTH=4, SETTLE=0, ideal comparator with input 11
    logic       rst_b, start_b, cmp_b;
    logic       sample_b, busy_b, valid_b;
    logic [3:0] dac_b, result_b;

    assign cmp_b = (4'd11 >= dac_b);

    sar_ctrl #(.WIDTH(4), .SETTLE(0)) u_dut_b (
        .clock  (clock),
        .rst    (rst_b),
        .start  (start_b),
        .cmp    (cmp_b),
        .sample (sample_b),
        .dac    (dac_b),
        .busy   (busy_b),
        .result (result_b),
        .valid  (valid_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Ideal SAR: while testing bit i, the code shown is vin's bits above i
    // with bit i set. t counts cycles since the start edge (1 = sample cycle).
    function automatic int exp_dac(input int t, input int vin);
        int k, i;
        if (t < 2 || t >= TDONE) return 0;
        k = (t - 2) / (S + 1);
        i = W - 1 - k;
        return ((vin >> (i + 1)) << (i + 1)) | (1 << i);
    endfunction

    function automatic bit is_last(input int t);
        return (t >= 2) && (t < TDONE) && (((t - 2) % (S + 1)) == S);
    endfunction

    int t, vin, res_exp, conv_idx;
    int seq_b[4] = '{8, 12, 10, 11};

    initial begin
        rst = 1'b0; start = 1'b0; cmp = 1'b0;
        rst_b = 1'b0; start_b = 1'b0;
        t = 0; vin = 0; res_exp = 0; conv_idx = 0;

        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk_eq("rst_sample", 32'(sample), 32'd0);
        chk_eq("rst_busy",   32'(busy),   32'd0);
        chk_eq("rst_valid",  32'(valid),  32'd0);
        chk_eq("rst_dac",    32'(dac),    32'd0);
        chk_eq("rst_result", 32'(result), 32'd0);
        chk_eq("rst_b_busy", 32'(busy_b), 32'd0);
        chk_eq("rst_b_dac",  32'(dac_b),  32'd0);
        chk_eq("rst_b_res",  32'(result_b), 32'd0);

        // Directed 4-bit conversion; a second start mid-trial must be ignored.
        rst_b   = 1'b1;
        start_b = 1'b1;
        @(posedge clock);
        #1 start_b = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            chk_eq($sformatf("b_sample_c%0d", c), 32'(sample_b), 32'(c == 1));
            chk_eq($sformatf("b_busy_c%0d", c),   32'(busy_b),   32'(c <= 6));
            chk_eq($sformatf("b_valid_c%0d", c),  32'(valid_b),  32'(c == 6));
            if (c >= 2 && c <= 5)
                chk_eq($sformatf("b_dac_c%0d", c), 32'(dac_b), 32'(seq_b[c-2]));
            if (c >= 6)
                chk_eq($sformatf("b_result_c%0d", c), 32'(result_b), 32'd11);
            start_b = (c == 3);
        end

        // Randomized run of the main instance against the timeline model.
        rst = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            chk_eq("sample", 32'(sample), 32'(t == 1));
            chk_eq("busy",   32'(busy),   32'(t != 0));
            chk_eq("valid",  32'(valid),  32'(t == TDONE));
            chk_eq("result", 32'(result), 32'(res_exp));
            if (t != TDONE)
                chk_eq("dac", 32'(dac), 32'(exp_dac(t, vin)));

            rst = !(($urandom_range(0, 299) == 0) || (conv_idx == 4 && t == 10));
            if (t == 0 || t == TDONE)
                start = ($urandom_range(0, 1) == 1);
            else
                start = ($urandom_range(0, 3) == 0);
            if (is_last(t))
                cmp = (vin >= exp_dac(t, vin));
            else
                cmp = ($urandom_range(0, 1) == 1);

            @(posedge clock);
            if (!rst) begin
                t = 0;
                res_exp = 0;
            end else if (t == 0 || t == TDONE) begin
                if (start) begin
                    t = 1;
                    conv_idx++;
                    if (conv_idx == 1)      vin = 0;
                    else if (conv_idx == 2) vin = 255;
                    else                    vin = int'($urandom_range(0, 255));
                end else begin
                    t = 0;
                end
            end else begin
                t++;
                if (t == TDONE) res_exp = vin;
            end
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
